mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port memory between instruction fetch (IF) and data load/store (D) requesters.
//  Sits between if_top/mem_top and the memory array. Upstream address routing has already selected
//  the memory region; this block only decides who owns the port and when.
//  Sequences each access (issue, wait, respond) and tags returned read data to the owner.
// PARAMETERS
//  ADDR_W      32  request/memory address width
//  DATA_W      32  data width
//  MEM_LAT     1   cycles from o_mem_en to valid i_mem_rdata (>=1)
//  STARVE_MAX  4   consecutive D grants tolerated while IF waits (guard build only)
// PORTS
//  i_clk         in   1       core clock
//  i_reset_n     in   1       async reset, active low
//  i_if_req      in   1       IF read request; held until o_if_gnt
//  i_if_addr     in   ADDR_W  IF read address
//  o_if_gnt      out  1       1-cycle pulse: IF request accepted
//  o_if_rvalid   out  1       1-cycle pulse: o_if_rdata valid
//  o_if_rdata    out  DATA_W  IF read data, held until the next IF read returns
//  i_d_req       in   1       D request; held until o_d_gnt
//  i_d_we        in   1       1=write, 0=read
//  i_d_addr      in   ADDR_W  D address
//  i_d_wdata     in   DATA_W  D write data
//  o_d_gnt       out  1       1-cycle pulse: D request accepted
//  o_d_rvalid    out  1       1-cycle pulse: o_d_rdata valid (reads only)
//  o_d_rdata     out  DATA_W  D read data, held until the next D read returns
//  o_mem_en      out  1       memory access strobe
//  o_mem_we      out  1       memory write enable (qualified by o_mem_en)
//  o_mem_addr    out  ADDR_W  memory address, passed unchanged
//  o_mem_wdata   out  DATA_W  memory write data
//  i_mem_rdata   in   DATA_W  memory read data
//  o_busy        out  1       high whenever state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, all outputs 0, latched addr/wdata/owner 0, starve count 0.
//  - FSM IDLE -> ISSUE -> (write: IDLE | read: WAIT -> IDLE).
//  - IDLE: sample requests. Winner is D if i_d_req, else IF if i_if_req. Latch addr, we (IF forces 0),
//    wdata and owner; go to ISSUE. With no request, stay in IDLE.
//  - ISSUE (1 cycle): o_mem_en=1, o_mem_we/addr/wdata from latches, owner's gnt=1.
//    Write -> IDLE. Read -> WAIT with counter=MEM_LAT-1.
//  - WAIT (MEM_LAT cycles): i_mem_rdata is valid in the final WAIT cycle. At that edge capture it into
//    the owner's rdata, then go to IDLE.
//    The owner's rvalid is high for exactly the first IDLE cycle after WAIT.
//  - Read latency: req sampled at cycle 0 -> gnt at 1 -> rvalid at 2+MEM_LAT. Write: gnt at 1, no rvalid.
//  - Requests are not sampled in ISSUE/WAIT. A requester that drops req before gnt is not served.
//    Arbitration in the rvalid cycle is legal, giving back-to-back accesses.
//  - At most one gnt and at most one rvalid asserted in any cycle. The non-owner's rdata never changes.
//  - Simultaneous IF+D in IDLE: D wins. IF stays pending and wins the next IDLE if D is idle.
//  - Reset mid-operation: access aborted, o_mem_en drops immediately, no rvalid or gnt is emitted.
//    Requesters must reissue.
//  - No address arithmetic. o_mem_addr = latched address bit-for-bit.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined: a counter (width clog2(STARVE_MAX+1)) increments on each D grant
//    made while i_if_req=1. When it equals STARVE_MAX, the next IDLE arbitration grants IF even if
//    i_d_req=1. The counter clears on any IF grant, and on an IDLE arbitration with i_if_req=0.
//  ARB_STARVE_GUARD_EN undefined: strict D priority, no counter logic; IF may starve indefinitely.
// TESTING
//  1. Reset release, IF read 0x0000_0040, mem returns 0xDEAD_BEEF (MEM_LAT=1) ->
//     o_if_gnt @c1, o_mem_en @c1, o_if_rvalid @c3 with o_if_rdata=0xDEAD_BEEF.
//  2. D write 0x0000_0100 <= 0x1234_5678 -> o_mem_en=o_mem_we=1 with that addr/data @c1,
//     o_d_gnt @c1, no rvalid, o_busy low @c2.
//  3. IF and D read asserted same cycle -> D granted first; IF granted in the D rvalid cycle+1;
//     o_if_rdata unchanged during the D read.
//  4. Guard build, STARVE_MAX=4, D and IF held high -> 4 D grants then 1 IF grant, repeating;
//     without the macro: only D grants.
//  5. Reset asserted during WAIT of an IF read -> o_mem_en, gnts and rvalids 0 immediately.
//     After release, IF req held -> fresh gnt 1 cycle later.
//  6. MEM_LAT=3, D read -> rvalid exactly at c5; rdata captured from the c4 i_mem_rdata value.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch (IF)
// and data (D) requesters. Each access runs issue -> wait -> respond, and read
// data is returned to the owner of the access.
//
// Optional feature: define ARB_STARVE_GUARD_EN to bound how many consecutive
// D grants may be made while IF is waiting. Without it, D has strict priority.
//
// Ports
//   i_clk, i_reset_n           clock, async active-low reset
//   i_if_req/i_if_addr         IF read request (held until o_if_gnt)
//   o_if_gnt/o_if_rvalid       IF accept pulse / read-data-valid pulse
//   o_if_rdata                 IF read data, held until the next IF read returns
//   i_d_req/i_d_we/i_d_addr    D request (held until o_d_gnt), write flag, address
//   i_d_wdata                  D write data
//   o_d_gnt/o_d_rvalid         D accept pulse / read-data-valid pulse (reads only)
//   o_d_rdata                  D read data, held until the next D read returns
//   o_mem_en/o_mem_we          memory strobe / write enable
//   o_mem_addr/o_mem_wdata     memory address / write data
//   i_mem_rdata                memory read data
//   o_busy                     high whenever the FSM is not idle
//
// State table
//   state   | meaning
//   S_IDLE  | arbitrate; rvalid of a just-finished read shows here
//   S_ISSUE | drive the memory strobe for one cycle, pulse owner's gnt
//   S_WAIT  | read in flight; data valid in the last WAIT cycle
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_d_req,
   input  logic              i_d_we,
   input  logic [ADDR_W-1:0] i_d_addr,
   input  logic [DATA_W-1:0] i_d_wdata,
   output logic              o_d_gnt,
   output logic              o_d_rvalid,
   output logic [DATA_W-1:0] o_d_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
      $error("mem_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              owner_d_q;   // 1: current access belongs to D
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
   logic              if_rvalid_q, d_rvalid_q;
   logic              force_if;
   logic              grant_d, grant_if, arb_now, rd_done;

   assign arb_now  = (state_q == S_IDLE);
   assign grant_d  = arb_now && i_d_req && !force_if;
   assign grant_if = arb_now && i_if_req && !grant_d;
   assign rd_done  = (state_q == S_WAIT) && (cnt_q == '0);

`ifdef ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_MAX + 1);
   logic [SC_W-1:0] starve_q;

   // Counts D wins taken while IF was waiting; at the limit IF is forced through.
   assign force_if = i_if_req && (starve_q == SC_W'(STARVE_MAX));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         starve_q <= '0;
      end else if (arb_now) begin
         if (grant_if || !i_if_req)
            starve_q <= '0;
         else if (grant_d)
            starve_q <= starve_q + 1'b1;
      end
   end
`else
   assign force_if = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         owner_d_q   <= 1'b0;
         cnt_q       <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant_d || grant_if) begin
            addr_q    <= grant_d ? i_d_addr : i_if_addr;
            wdata_q   <= grant_d ? i_d_wdata : '0;
            we_q      <= grant_d && i_d_we;
            owner_d_q <= grant_d;
         end
         if (state_q == S_ISSUE)
            cnt_q <= CNT_W'(MEM_LAT - 1);
         else if (state_q == S_WAIT && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
         if_rvalid_q <= rd_done && !owner_d_q;
         d_rvalid_q  <= rd_done && owner_d_q;
         if (rd_done && !owner_d_q)
            if_rdata_q <= i_mem_rdata;
         if (rd_done && owner_d_q)
            d_rdata_q <= i_mem_rdata;
      end
   end

   always_comb begin
      state_d  = state_q;
      o_mem_en = 1'b0;
      o_if_gnt = 1'b0;
      o_d_gnt  = 1'b0;
      o_busy   = 1'b1;
      case (state_q)
         S_IDLE: begin
            o_busy = 1'b0;
            if (grant_d || grant_if)
               state_d = S_ISSUE;
         end
         S_ISSUE: begin
            o_mem_en = 1'b1;
            o_if_gnt = !owner_d_q;
            o_d_gnt  = owner_d_q;
            state_d  = we_q ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_mem_we    = o_mem_en && we_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_d_rdata   = d_rdata_q;
   assign o_if_rvalid = if_rvalid_q;
   assign o_d_rvalid  = d_rvalid_q;

endmodule
